// File: rtl/matrix_pkg.sv
// Shared types and constants for the LED matrix scan controller and its row timer.
// Grant encodings are one-hot so the grant word drives the data select directly.
package matrix_pkg;

    localparam int MATRIX_ROWS = 8;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_SRC0 = 2'b01;
    localparam logic [1:0] GRANT_SRC1 = 2'b10;

    typedef enum logic [1:0] {
        BLANK,
        FETCH,
        LATCH,
        DRIVE
    } phase_t;

    // Maps a position inside a row slot to its phase.
    function automatic phase_t decode_phase(input int cnt, input int blank_cycles);
        if (cnt < blank_cycles)
            return BLANK;
        else if (cnt == blank_cycles)
            return FETCH;
        else if (cnt == blank_cycles + 1)
            return LATCH;
        else
            return DRIVE;
    endfunction

endpackage

// File: rtl/matrix_row_timer.sv
// Row-slot timing: cycle counter, row index, phase, fetch strobe and frame start.
// The *_next outputs describe the position the next clock edge moves into.
module matrix_row_timer
    import matrix_pkg::*;
#(
    parameter int ROW_CYCLES   = 8192,
    parameter int BLANK_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    output logic [2:0] row_idx,
    output logic       fetch_stb,
    output logic       frame_start,
    output logic [2:0] row_next,
    output logic       boundary_next,
    output logic       latch_now,
    output logic       drive_next
);

    localparam int CW = $clog2(ROW_CYCLES);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [2:0]    row_nx;
    logic          run;
    phase_t        phase;
    phase_t        phase_nx;

    // The first edge after reset enters position (0, 0) instead of advancing,
    // so the frame boundary is presented in the very first running cycle.
    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        cnt_nx = '0;
        row_nx = '0;
        if (run) begin
            cnt_nx = cnt + CW'(1);
            row_nx = (&cnt) ? row_idx + 3'd1 : row_idx;
        end
        phase_nx = decode_phase(32'(cnt_nx), BLANK_CYCLES);
    end

    assign row_next      = row_nx;
    assign boundary_next = (cnt_nx == '0) && (row_nx == '0);
    assign latch_now     = (phase == LATCH);
    assign drive_next    = (phase_nx == DRIVE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run         <= 1'b0;
            cnt         <= '0;
            row_idx     <= '0;
            phase       <= BLANK;
            fetch_stb   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            run         <= 1'b1;
            cnt         <= cnt_nx;
            row_idx     <= row_nx;
            phase       <= phase_nx;
            fetch_stb   <= (phase_nx == FETCH);
            frame_start <= boundary_next;
        end
    end

endmodule

// File: rtl/matrix_scan_arbiter.sv
// Row-scan controller for the shared 8x8 red/green matrix: arbitrates between the
// game layer (src0) and the overlay (src1) at frame boundaries and drives the pins.
module matrix_scan_arbiter
    import matrix_pkg::*;
#(
    parameter int ROW_CYCLES   = 8192,
    parameter int BLANK_CYCLES = 64,
    parameter int HOLD_FRAMES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       src0_req,
    input  logic       src1_req,
    output logic       fetch_stb,
    output logic [2:0] row_idx,
    input  logic [7:0] src0_r,
    input  logic [7:0] src0_g,
    input  logic [7:0] src1_r,
    input  logic [7:0] src1_g,
    output logic [1:0] grant,
    output logic       frame_start,
    output logic [7:0] matrix_segout_r,
    output logic [7:0] matrix_segout_g,
    output logic [7:0] matrix_scanout
);

    localparam logic [3:0] HOLD_MAX = 4'(HOLD_FRAMES);

    logic [2:0] row_next;
    logic       boundary_next;
    logic       latch_now;
    logic       drive_next;

    logic [3:0] hold;
    logic [3:0] hold_nx;
    logic [1:0] grant_nx;
    logic [7:0] sel_r;
    logic [7:0] sel_g;

    matrix_row_timer #(
        .ROW_CYCLES  (ROW_CYCLES),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_timer (
        .clk          (clk),
        .reset        (reset),
        .row_idx      (row_idx),
        .fetch_stb    (fetch_stb),
        .frame_start  (frame_start),
        .row_next     (row_next),
        .boundary_next(boundary_next),
        .latch_now    (latch_now),
        .drive_next   (drive_next)
    );

    // Grant only moves on the edge that enters a frame boundary; a live grant is
    // held until it has owned HOLD_FRAMES whole frames.
    always_comb begin
        grant_nx = grant;
        hold_nx  = hold;
        if (boundary_next) begin
            if ((hold < HOLD_MAX) && (grant != GRANT_NONE)) begin
                hold_nx = hold + 4'd1;
            end else begin
                if (src1_req)
                    grant_nx = GRANT_SRC1;
                else if (src0_req)
                    grant_nx = GRANT_SRC0;
                else
                    grant_nx = GRANT_NONE;
                hold_nx = (grant_nx != grant) ? 4'd1 : HOLD_MAX;
            end
        end
    end

    always_comb begin
        sel_r = '0;
        sel_g = '0;
        case (grant)
            GRANT_SRC0: begin
                sel_r = src0_r;
                sel_g = src0_g;
            end
            GRANT_SRC1: begin
                sel_r = src1_r;
                sel_g = src1_g;
            end
            default: ;
        endcase
    end

    // The column registers double as the row store: loaded on the edge leaving
    // LATCH, held through DRIVE, cleared whenever the next cycle is not DRIVE.
    // NOTE: no memories here; every register has an async reset so the pins go dark at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant           <= GRANT_NONE;
            hold            <= '0;
            matrix_segout_r <= '0;
            matrix_segout_g <= '0;
            matrix_scanout  <= '0;
        end else begin
            grant <= grant_nx;
            hold  <= hold_nx;
            if (drive_next) begin
                if (latch_now) begin
                    matrix_segout_r <= sel_r;
                    matrix_segout_g <= sel_g;
                end
                matrix_scanout <= 8'(1) << row_next;
            end else begin
                matrix_segout_r <= '0;
                matrix_segout_g <= '0;
                matrix_scanout  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_matrix_scan_arbiter.sv
// Self-checking bench for matrix_scan_arbiter: frame-level vector table feeding a
// per-cycle scoreboard, plus a hand-written mid-row reset sequence.
module tb_matrix_scan_arbiter;

    localparam int ROWC  = 16;
    localparam int BLANK = 2;
    localparam int FRAME = ROWC * 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       src0_req, src1_req;
    logic       fetch_stb, frame_start;
    logic [2:0] row_idx;
    logic [7:0] src0_r, src0_g, src1_r, src1_g;
    logic [1:0] grant;
    logic [7:0] seg_r, seg_g, scan;

    matrix_scan_arbiter #(
        .ROW_CYCLES  (ROWC),
        .BLANK_CYCLES(BLANK),
        .HOLD_FRAMES (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .src0_req       (src0_req),
        .src1_req       (src1_req),
        .fetch_stb      (fetch_stb),
        .row_idx        (row_idx),
        .src0_r         (src0_r),
        .src0_g         (src0_g),
        .src1_r         (src1_r),
        .src1_g         (src1_g),
        .grant          (grant),
        .frame_start    (frame_start),
        .matrix_segout_r(seg_r),
        .matrix_segout_g(seg_g),
        .matrix_scanout (scan)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       fs;
        logic       stb;
        logic [2:0] row;
        logic [1:0] gnt;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] scan;
    } obs_t;

    typedef struct {
        logic       s0b, s1b;   // requests presented at the boundary that starts the frame
        logic       s0m, s1m;   // requests during the body of the frame
        logic [7:0] s0r, s0g, s1r, s1g;
        logic [1:0] exp_grant;
    } frame_vec_t;

    obs_t sb_q[$];
    int   checks = 0;
    int   passes = 0;

    function automatic obs_t sample();
        obs_t o;
        o = '{fs: frame_start, stb: fetch_stb, row: row_idx, gnt: grant,
              r: seg_r, g: seg_g, scan: scan};
        return o;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s @%0t: got fs=%0b stb=%0b row=%0d gnt=%b r=%h g=%h scan=%h, expected fs=%0b stb=%0b row=%0d gnt=%b r=%h g=%h scan=%h",
                     name, $time, act.fs, act.stb, act.row, act.gnt, act.r, act.g, act.scan,
                     exp.fs, exp.stb, exp.row, exp.gnt, exp.r, exp.g, exp.scan);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            obs_t e;
            e = sb_q.pop_front();
            check("cycle", sample(), e);
        end
    end

    // Drives one frame (or its first ncyc cycles) and queues the expected pins per cycle.
    task automatic run_frame(input frame_vec_t v, input logic nxt_s0, input logic nxt_s1,
                             input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            obs_t e;
            int   k;
            int   row;
            logic drive;
            @(posedge clk);
            #1;
            k   = c % ROWC;
            row = c / ROWC;
            if (c == 0) begin
                src0_req = v.s0b;
                src1_req = v.s1b;
            end else if (c == FRAME - 1) begin
                src0_req = nxt_s0;
                src1_req = nxt_s1;
            end else begin
                src0_req = v.s0m;
                src1_req = v.s1m;
            end
            // Only the cycle after fetch_stb carries real data; anything else must be ignored.
            if (k == BLANK + 1) begin
                src0_r = v.s0r; src0_g = v.s0g; src1_r = v.s1r; src1_g = v.s1g;
            end else begin
                src0_r = 8'($urandom); src0_g = 8'($urandom);
                src1_r = 8'($urandom); src1_g = 8'($urandom);
            end
            drive  = (k >= BLANK + 2);
            e      = '0;
            e.fs   = (c == 0);
            e.stb  = (k == BLANK);
            e.row  = 3'(row);
            e.gnt  = v.exp_grant;
            e.scan = drive ? (8'(1) << row) : 8'h00;
            if (drive && v.exp_grant == 2'b01) begin
                e.r = v.s0r; e.g = v.s0g;
            end else if (drive && v.exp_grant == 2'b10) begin
                e.r = v.s1r; e.g = v.s1g;
            end
            sb_q.push_back(e);
        end
    endtask

    task automatic idle_cycle(input logic rst_level);
        @(posedge clk);
        #1;
        reset = rst_level;
        sb_q.push_back('0);
    endtask

    frame_vec_t vecs[8];
    frame_vec_t v8, v9;

    initial begin
        //            s0b   s1b   s0m   s1m   s0r    s0g    s1r    s1g    grant
        vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 8'h0F, 8'h11, 8'h3C, 2'b01};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h5A, 8'hF0, 8'h22, 8'h3C, 2'b01};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h81, 8'h18, 8'hC3, 8'h3C, 2'b10};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h01, 8'h80, 8'h7E, 8'hE7, 2'b10};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h99, 8'h66, 2'b01};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h33, 8'hCC, 8'h44, 8'h55, 2'b01};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 2'b00};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h96, 8'h69, 8'h12, 8'h34, 2'b01};
        v8      = '{1'b1, 1'b0, 1'b1, 1'b0, 8'hC0, 8'h03, 8'hAA, 8'h55, 2'b01};
        v9      = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h0A, 8'hB0, 8'hE1, 8'h1E, 2'b10};

        reset    = 1'b0;
        src0_req = 1'b1;
        src1_req = 1'b0;
        src0_r   = '0; src0_g = '0; src1_r = '0; src1_g = '0;

        // Reset held with src0 requesting: everything dark, then released mid-cycle.
        for (int i = 0; i < 3; i++) idle_cycle(1'b0);
        idle_cycle(1'b1);

        for (int f = 0; f < 8; f++) begin
            if (f < 7) run_frame(vecs[f], vecs[f+1].s0b, vecs[f+1].s1b, FRAME);
            else       run_frame(vecs[f], v8.s0b, v8.s1b, FRAME);
        end

        // Stop inside the DRIVE phase of row 5, then reset asynchronously.
        run_frame(v8, 1'b1, 1'b0, 5 * ROWC + BLANK + 6);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        src0_req = 1'b1;
        src1_req = 1'b1;
        sb_q.push_back('0);
        #1;
        check("async_reset_blank", sample(), '0);
        idle_cycle(1'b0);
        idle_cycle(1'b1);
        run_frame(v9, 1'b1, 1'b1, FRAME);

        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            checks++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
